// File: rtl/axis_processor_bridge_pkg.sv
// rtl/axis_processor_bridge_pkg.sv - sizing helpers shared by the AXIS bridge and its FIFO
package axis_bridge_config;

    localparam int ERR_WIDTH = 16;

    // Whole bytes needed to carry a word of the given bit width.
    function automatic int bytes_of(input int bits);
        return (bits + 7) / 8;
    endfunction

    // Lanes of lane_bytes needed to move a word of word_bytes.
    function automatic int beats_of(input int word_bytes, input int lane_bytes);
        return word_bytes / lane_bytes;
    endfunction

    // Counter width able to index n states; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_processor_bridge_fifo.sv
// rtl/axis_processor_bridge_fifo.sv - first-word-fall-through synchronous FIFO
module axis_bridge_fifo
    import axis_bridge_config::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // The extra pointer bit separates the full and empty cases when addresses match.
    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axis_processor_bridge.sv
// rtl/axis_processor_bridge.sv - AXIS upsizer to network_source, FIFO + downsizer from network_sink
module axis_processor_bridge
    import axis_bridge_config::*;
#(
    parameter int S_BYTES     = 1,
    parameter int M_BYTES     = 1,
    parameter int INP_WIDTH   = 8,
    parameter int SNK_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 0
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic [S_BYTES*8-1:0]   s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [INP_WIDTH-1:0]   src,
    output logic                   src_valid,
    input  logic                   src_ready,
    input  logic [SNK_WIDTH-1:0]   snk,
    input  logic                   snk_valid,
    output logic                   snk_ready,
    output logic [M_BYTES*8-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [ERR_WIDTH-1:0]   err_count
);

    localparam int INP_BYTES = bytes_of(INP_WIDTH);
    localparam int OUT_BYTES = bytes_of(SNK_WIDTH);
    localparam int IN_BEATS  = beats_of(INP_BYTES, S_BYTES);
    localparam int OUT_BEATS = beats_of(OUT_BYTES, M_BYTES);
    localparam int IW        = INP_BYTES * 8;
    localparam int SW        = S_BYTES * 8;
    localparam int OW        = OUT_BYTES * 8;
    localparam int MW        = M_BYTES * 8;
    localparam int IBW       = cnt_width(IN_BEATS);
    localparam int OBW       = cnt_width(OUT_BEATS);
    localparam int FW        = cnt_width(FRAME_WORDS);

    localparam logic [IBW-1:0] IN_LAST  = IBW'(IN_BEATS - 1);
    localparam logic [OBW-1:0] OUT_LAST = OBW'(OUT_BEATS - 1);
    localparam logic [FW-1:0]  FR_LAST  = FW'(FRAME_WORDS - 1);

    if ((INP_BYTES % S_BYTES) != 0) begin : g_bad_in_ratio
        $fatal(1, "INP_BYTES must be a multiple of S_BYTES");
    end
    if ((OUT_BYTES % M_BYTES) != 0) begin : g_bad_out_ratio
        $fatal(1, "OUT_BYTES must be a multiple of M_BYTES");
    end

    // ---------------- assembler ----------------
    logic [IW-1:0]        asm_q, asm_d;
    logic [IBW-1:0]       beat_q, beat_d;
    logic                 full_q, full_d;
    logic [ERR_WIDTH-1:0] err_q, err_d;
    logic                 s_accept;

    // Beats shift in at the bottom, so the first beat ends up in the top bytes.
    always_comb begin
        s_axis_tready = !full_q || src_ready;
        s_accept      = s_axis_tvalid && s_axis_tready;
        asm_d         = asm_q;
        beat_d        = beat_q;
        full_d        = full_q;
        err_d         = err_q;
        if (full_q && src_ready) full_d = 1'b0;
        if (s_accept) begin
            asm_d = (asm_q << SW) | IW'(s_axis_tdata);
            if (beat_q == IN_LAST) begin
                beat_d = '0;
                full_d = 1'b1;
            end else if (s_axis_tlast) begin
                beat_d = '0;
                if (err_q != '1) err_d = err_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            asm_q  <= '0;
            beat_q <= '0;
            full_q <= 1'b0;
            err_q  <= '0;
        end else begin
            asm_q  <= asm_d;
            beat_q <= beat_d;
            full_q <= full_d;
            err_q  <= err_d;
        end
    end

    assign src       = asm_q[IW-1 -: INP_WIDTH];
    assign src_valid = full_q;
    assign err_count = err_q;

    // ---------------- output FIFO ----------------
    logic          fifo_full, fifo_empty, fifo_rd;
    logic [OW-1:0] fifo_wdata, fifo_rdata;

    assign snk_ready  = !fifo_full;
    assign fifo_wdata = OW'(snk) << (OW - SNK_WIDTH);

    axis_bridge_fifo #(
        .WIDTH (OW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arstn   (arstn),
        .wr_en   (snk_valid && snk_ready),
        .wr_data (fifo_wdata),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty)
    );

    // ---------------- serializer ----------------
    logic [OW-1:0]  word_q, word_d;
    logic [OBW-1:0] obeat_q, obeat_d, obeat_nx;
    logic [FW-1:0]  frame_q, frame_d;
    logic           tvalid_q, tvalid_d;
    logic           tlast_q, tlast_d;
    logic           beat_acc, last_acc;

    function automatic logic frame_done(input logic [FW-1:0] f);
        return (FRAME_WORDS == 0) || (f == FR_LAST);
    endfunction

    always_comb begin
        beat_acc = tvalid_q && m_axis_tready;
        last_acc = beat_acc && (obeat_q == OUT_LAST);
        fifo_rd  = !fifo_empty && (!tvalid_q || last_acc);
        obeat_nx = obeat_q + 1'b1;
        word_d   = word_q;
        obeat_d  = obeat_q;
        frame_d  = frame_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (last_acc) frame_d = frame_done(frame_q) ? '0 : frame_q + 1'b1;
        // A pop on the final-beat handshake must see the already-advanced frame position.
        if (fifo_rd) begin
            word_d   = fifo_rdata;
            obeat_d  = '0;
            tvalid_d = 1'b1;
            tlast_d  = (OUT_BEATS == 1) && frame_done(frame_d);
        end else if (last_acc) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end else if (beat_acc) begin
            word_d   = word_q << MW;
            obeat_d  = obeat_nx;
            tlast_d  = (obeat_nx == OUT_LAST) && frame_done(frame_q);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            word_q   <= '0;
            obeat_q  <= '0;
            frame_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            word_q   <= word_d;
            obeat_q  <= obeat_d;
            frame_q  <= frame_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign m_axis_tdata  = word_q[OW-1 -: MW];
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_processor_bridge.sv
// tb/tb_axis_processor_bridge.sv - self-checking bench for axis_processor_bridge (24-bit src, 12-bit snk, 3-word frames)
module tb_axis_processor_bridge;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [23:0] src;
    logic        src_valid;
    logic        src_ready = 1'b1;
    logic [11:0] snk = '0;
    logic        snk_valid = 1'b0;
    logic        snk_ready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [15:0] err_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axis_processor_bridge #(
        .S_BYTES     (1),
        .M_BYTES     (1),
        .INP_WIDTH   (24),
        .SNK_WIDTH   (12),
        .FIFO_DEPTH  (4),
        .FRAME_WORDS (3)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .src           (src),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .snk           (snk),
        .snk_valid     (snk_valid),
        .snk_ready     (snk_ready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .err_count     (err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte list per command, queue of words owed to src, queue of {tlast,byte} owed to m_axis.
    logic [7:0]  in_bytes[$];
    logic [23:0] exp_src[$];
    logic [8:0]  exp_beats[$];
    int          exp_err = 0;
    int          snk_words = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [7:0]  prev_d = '0;

    always @(negedge clk) begin
        logic [15:0] w;
        if (!arstn) begin
            in_bytes.delete();
            exp_src.delete();
            exp_beats.delete();
            exp_err   = 0;
            snk_words = 0;
            prev_v    = 1'b0;
        end else begin
            chk("src_valid", {31'd0, src_valid}, {31'd0, exp_src.size() != 0});
            if (src_valid && exp_src.size() != 0) chk("src", {8'd0, src}, {8'd0, exp_src[0]});
            chk("s_tready", {31'd0, s_tready}, {31'd0, (exp_src.size() == 0) || src_ready});
            chk("err_count", {16'd0, err_count}, exp_err);
            if (prev_v && !prev_r)
                chk("m_hold", {22'd0, m_tvalid, m_tlast, m_tdata}, {22'd0, 1'b1, prev_l, prev_d});
            if (m_tvalid && m_tready) begin
                chk("m_beat_owed", {31'd0, exp_beats.size() != 0}, 32'd1);
                if (exp_beats.size() != 0)
                    chk("m_beat", {23'd0, m_tlast, m_tdata}, {23'd0, exp_beats.pop_front()});
            end
            prev_v = m_tvalid;
            prev_r = m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;

            if (src_valid && src_ready && exp_src.size() != 0) void'(exp_src.pop_front());
            if (s_tvalid && s_tready) begin
                in_bytes.push_back(s_tdata);
                if (in_bytes.size() == 3) begin
                    exp_src.push_back({in_bytes[0], in_bytes[1], in_bytes[2]});
                    in_bytes.delete();
                end else if (s_tlast) begin
                    in_bytes.delete();
                    if (exp_err < 65535) exp_err++;
                end
            end
            if (snk_valid && snk_ready) begin
                w = {snk, 4'h0};
                exp_beats.push_back({1'b0, w[15:8]});
                exp_beats.push_back({(snk_words % 3) == 2, w[7:0]});
                snk_words++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) chk("s_tready_timeout", {31'd0, s_tready}, 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    logic [7:0] lit [6] = '{8'h12, 8'h30, 8'h45, 8'h60, 8'hAB, 8'hC0};

    initial begin
        int vcnt, first, last, lcnt, n;

        arstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        arstn = 1'b1;
        @(negedge clk);
        chk("rst_src_valid", {31'd0, src_valid}, 32'd0);
        chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_err", {16'd0, err_count}, 32'd0);
        chk("rst_s_tready", {31'd0, s_tready}, 32'd1);
        chk("rst_snk_ready", {31'd0, snk_ready}, 32'd1);
        cyc();

        // Normal three-beat word and its one-cycle latency.
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b0);
        chk("src_not_early", {31'd0, src_valid}, 32'd0);
        beat(8'hCC, 1'b1);
        @(negedge clk);
        chk("src_aabbcc_valid", {31'd0, src_valid}, 32'd1);
        chk("src_aabbcc", {8'd0, src}, 32'h00AABBCC);
        chk("err_zero", {16'd0, err_count}, 32'd0);
        cyc();

        // Short command is discarded and counted.
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b1);
        @(negedge clk);
        chk("err_one", {16'd0, err_count}, 32'd1);
        chk("no_src_after_err", {31'd0, src_valid}, 32'd0);
        cyc();
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b0);
        beat(8'h55, 1'b1);
        @(negedge clk);
        chk("src_334455", {8'd0, src}, 32'h00334455);
        cyc();

        // Source backpressure, then zero-bubble retire + capture.
        src_ready = 1'b0;
        beat(8'h66, 1'b0);
        beat(8'h77, 1'b0);
        beat(8'h88, 1'b0);
        s_tdata  = 8'h99;
        s_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_s_tready", {31'd0, s_tready}, 32'd0);
            chk("stall_src", {8'd0, src}, 32'h00667788);
        end
        @(posedge clk);
        #1;
        src_ready = 1'b1;
        @(negedge clk);
        chk("release_s_tready", {31'd0, s_tready}, 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("retired_src_valid", {31'd0, src_valid}, 32'd0);
        cyc();
        beat(8'h9A, 1'b0);
        beat(8'h9B, 1'b0);
        @(negedge clk);
        chk("src_999a9b", {8'd0, src}, 32'h00999A9B);
        cyc();

        // Downsizer byte order, two-cycle latency and first frame tlast.
        snk = 12'h123;
        snk_valid = 1'b1;
        cyc();
        chk("m_not_early", {31'd0, m_tvalid}, 32'd0);
        snk = 12'h456;
        cyc();
        snk = 12'hABC;
        for (int i = 0; i < 6; i++) begin
            chk("lit_tvalid", {31'd0, m_tvalid}, 32'd1);
            chk("lit_tdata", {24'd0, m_tdata}, {24'd0, lit[i]});
            chk("lit_tlast", {31'd0, m_tlast}, {31'd0, i == 5});
            cyc();
            if (i == 0) snk_valid = 1'b0;
        end
        chk("lit_idle", {31'd0, m_tvalid}, 32'd0);

        // Six back-to-back words: gapless, tlast on words 3 and 6.
        vcnt = 0; first = -1; last = -1; lcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 6) begin
                snk = 12'h101 * (i + 1);
                snk_valid = 1'b1;
            end else begin
                snk_valid = 1'b0;
            end
            @(negedge clk);
            if (m_tvalid) begin
                vcnt++;
                if (first < 0) first = i;
                last = i;
                if (m_tlast) lcnt++;
            end
            @(posedge clk);
            #1;
        end
        chk("frame_beats", vcnt, 32'd12);
        chk("frame_gapless", last - first + 1, 32'd12);
        chk("frame_tlast", lcnt, 32'd2);

        // FIFO fill against a stalled output.
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            snk = 12'h3C0 + 12'(i);
            snk_valid = 1'b1;
            @(negedge clk);
            chk("fill_snk_ready", {31'd0, snk_ready}, {31'd0, i < 5});
            @(posedge clk);
            #1;
        end
        snk_valid = 1'b0;
        chk("fill_owed_beats", exp_beats.size(), 32'd10);
        m_tready = 1'b1;
        n = 0;
        while (exp_beats.size() != 0 && n < 60) begin
            cyc();
            n++;
        end
        chk("drain_done", exp_beats.size(), 32'd0);
        repeat (3) cyc();
        chk("drain_idle", {31'd0, m_tvalid}, 32'd0);

        // Reset in the middle of an input word and a held output beat.
        m_tready = 1'b0;
        snk = 12'h777;
        snk_valid = 1'b1;
        cyc();
        snk_valid = 1'b0;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        chk("pre_rst_m_tvalid", {31'd0, m_tvalid}, 32'd1);
        arstn = 1'b0;
        #1;
        chk("mid_rst_src_valid", {31'd0, src_valid}, 32'd0);
        chk("mid_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("mid_rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        chk("mid_rst_err", {16'd0, err_count}, 32'd0);
        chk("mid_rst_s_tready", {31'd0, s_tready}, 32'd1);
        chk("mid_rst_snk_ready", {31'd0, snk_ready}, 32'd1);
        cyc();
        arstn = 1'b1;
        m_tready = 1'b1;
        repeat (5) begin
            cyc();
            chk("post_rst_quiet", {31'd0, m_tvalid}, 32'd0);
        end
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        beat(8'h05, 1'b1);
        @(negedge clk);
        chk("post_rst_src", {8'd0, src}, 32'h00030405);
        repeat (3) cyc();
        chk("src_owed_empty", exp_src.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
